sbc_seq_8bit: RTL



---
 rtl/sbc_seq_8bit.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/sbc_seq_8bit.sv
// Multi-cycle 8-bit subtract-with-borrow (SBC) for the 6502 ALU, binary and NMOS decimal modes.
// A + ~B + Cin is formed nibble-serially through one shared 4-bit carry-lookahead adder.
module sbc_seq_8bit #(
    parameter bit DEC_ENABLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic       dec,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       c_out,
    output logic       z_out,
    output logic       v_out,
    output logic       n_out
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLo   = 3'd1,
        StHi   = 3'd2,
        StAdj  = 3'd3,
        StFin  = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       cin_q, cin_d;
    logic       dec_q, dec_d;
    logic [4:0] lo5_q, lo5_d;
    logic [4:0] hi5_q, hi5_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] result_q, result_d;
    logic       c_q, c_d;
    logic       z_q, z_d;
    logic       v_q, v_d;
    logic       n_q, n_d;

    // Shared adder cell: low nibble in StLo, high nibble (with the low carry) in StHi.
    logic [3:0] add_x;
    logic [3:0] add_y;
    logic       add_ci;
    logic [3:0] add_g;
    logic [3:0] add_p;
    logic [4:0] add_c;
    logic [4:0] add_sum5;

    always_comb begin
        if (state_q == StHi) begin
            add_x  = a_q[7:4];
            add_y  = ~b_q[7:4];
            add_ci = lo5_q[4];
        end else begin
            add_x  = a_q[3:0];
            add_y  = ~b_q[3:0];
            add_ci = cin_q;
        end
    end

    always_comb begin
        add_g    = add_x & add_y;
        add_p    = add_x ^ add_y;
        add_c[0] = add_ci;
        add_c[1] = add_g[0] | (add_p[0] & add_ci);
        add_c[2] = add_g[1] | (add_p[1] & add_g[0]) | (add_p[1] & add_p[0] & add_ci);
        add_c[3] = add_g[2] | (add_p[2] & add_g[1]) | (add_p[2] & add_p[1] & add_g[0])
                 | (add_p[2] & add_p[1] & add_p[0] & add_ci);
        add_c[4] = add_g[3] | (add_p[3] & add_g[2]) | (add_p[3] & add_p[2] & add_g[1])
                 | (add_p[3] & add_p[2] & add_p[1] & add_g[0])
                 | (add_p[3] & add_p[2] & add_p[1] & add_p[0] & add_ci);
        add_sum5 = {add_c[4], add_p ^ add_c[3:0]};
    end

    // Binary result and flags; in StHi the high nibble comes straight from the adder.
    logic [4:0] hi5_cur;
    logic [7:0] bin_r;
    logic       bin_c;
    logic       bin_z;
    logic       bin_v;
    logic       bin_n;
    logic [3:0] lo_adj;
    logic [3:0] hi_adj;

    always_comb begin
        hi5_cur = (state_q == StHi) ? add_sum5 : hi5_q;
        bin_r   = {hi5_cur[3:0], lo5_q[3:0]};
        bin_c   = hi5_cur[4];
        bin_z   = (bin_r == 8'h00);
        bin_v   = (a_q[7] ^ b_q[7]) & (a_q[7] ^ bin_r[7]);
        bin_n   = bin_r[7];
        // NMOS decimal fix-up: subtract 6 from any nibble that borrowed.
        lo_adj  = lo5_q[4] ? lo5_q[3:0] : (lo5_q[3:0] - 4'd6);
        hi_adj  = hi5_q[4] ? hi5_q[3:0] : (hi5_q[3:0] - 4'd6);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLo;
            StLo:    state_d = StHi;
            StHi:    state_d = dec_q ? StAdj : StFin;
            StAdj:   state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        dec_d    = dec_q;
        lo5_d    = lo5_q;
        hi5_d    = hi5_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        c_d      = c_q;
        z_d      = z_q;
        v_d      = v_q;
        n_d      = n_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d    = a;
                    b_d    = b;
                    cin_d  = cin;
                    dec_d  = dec & DEC_ENABLE;
                    busy_d = 1'b1;
                end
            end
            StLo: begin
                lo5_d = add_sum5;
            end
            StHi: begin
                hi5_d = add_sum5;
                if (!dec_q) begin
                    result_d = bin_r;
                    c_d      = bin_c;
                    z_d      = bin_z;
                    v_d      = bin_v;
                    n_d      = bin_n;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            StAdj: begin
                result_d = {hi_adj, lo_adj};
                c_d      = bin_c;
                z_d      = bin_z;
                v_d      = bin_v;
                n_d      = bin_n;
                done_d   = 1'b1;
                busy_d   = 1'b0;
            end
            StFin: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            cin_q    <= 1'b0;
            dec_q    <= 1'b0;
            lo5_q    <= 5'h00;
            hi5_q    <= 5'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 8'h00;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            n_q      <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            dec_q    <= dec_d;
            lo5_q    <= lo5_d;
            hi5_q    <= hi5_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            c_q      <= c_d;
            z_q      <= z_d;
            v_q      <= v_d;
            n_q      <= n_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign c_out  = c_q;
    assign z_out  = z_q;
    assign v_out  = v_q;
    assign n_out  = n_q;

endmodule
